// File: rtl/avr_io_pkg.sv
// -----------------------------------------------------------------------------
// avr_io_pkg
// Shared I/O-space definitions for the avr_soc peripherals.
//   - Register offsets of a GPIO port window relative to its PIN address.
//   - Absolute I/O addresses of the port B instance.
//   - PCIFR bit positions.
//   - Register-select enum plus a decode helper used by the port peripheral.
// -----------------------------------------------------------------------------
package avr_io_pkg;

  // Offsets inside a GPIO port window (window base = PIN register address).
  localparam logic [7:0] OFF_PIN   = 8'd0;
  localparam logic [7:0] OFF_DDR   = 8'd1;
  localparam logic [7:0] OFF_PORT  = 8'd2;
  localparam logic [7:0] OFF_PCMSK = 8'd3;
  localparam logic [7:0] OFF_PCIFR = 8'd4;
  localparam logic [7:0] OFF_LAST  = OFF_PCIFR;

  // Port B instance addresses in the 6-bit I/O space.
  localparam logic [5:0] PINB_ADDR   = 6'h16;
  localparam logic [5:0] DDRB_ADDR   = 6'h17;
  localparam logic [5:0] PORTB_ADDR  = 6'h18;
  localparam logic [5:0] PCMSKB_ADDR = 6'h19;
  localparam logic [5:0] PCIFRB_ADDR = 6'h1A;

  // PCIFR bit indices.
  localparam int PCIF_BIT = 0;
  localparam int PCIE_BIT = 1;

  typedef enum logic [2:0] {
    REG_PIN,
    REG_DDR,
    REG_PORT,
    REG_PCMSK,
    REG_PCIFR,
    REG_NONE
  } io_reg_e;

  // Map a window offset to a register select; anything outside the window
  // (hit low) selects nothing.
  function automatic io_reg_e decode_reg(input logic hit, input logic [7:0] offset);
    io_reg_e sel;
    sel = REG_NONE;
    if (hit) begin
      unique case (offset)
        OFF_PIN:   sel = REG_PIN;
        OFF_DDR:   sel = REG_DDR;
        OFF_PORT:  sel = REG_PORT;
        OFF_PCMSK: sel = REG_PCMSK;
        OFF_PCIFR: sel = REG_PCIFR;
        default:   sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// Two-flop synchroniser for asynchronous input levels plus a one-cycle-delayed
// copy used for edge detection.
//   clk     in          system clock
//   reset   in          synchronous, active-high reset
//   d       in  WIDTH   raw asynchronous levels
//   s2      out WIDTH   synchronised levels (second stage)
//   change  out WIDTH   bits whose synchronised level differs from last cycle
// -----------------------------------------------------------------------------
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] change
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] prev;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign change = s2 ^ prev;

endmodule

// File: rtl/avr_gpio_port.sv
// -----------------------------------------------------------------------------
// avr_gpio_port
// Memory-mapped GPIO port on the avr_soc I/O bus with AVR-style PIN-write
// toggling and a maskable pin-change interrupt.
//   clk       in          system clock
//   reset     in          synchronous, active-high reset
//   io_addr   in  6       CPU I/O address
//   io_wr     in  1       write strobe (one cycle per write)
//   io_rd     in  1       read strobe (no side effects)
//   io_wdata  in  8       write data
//   io_rdata  out 8       read data, combinational; 8'h00 outside the window
//   io_sel    out 1       io_addr lies in BASE..BASE+4
//   port      out WIDTH   PORT register (output value / pull-up enable)
//   ddr       out WIDTH   DDR register (1 = output)
//   pin       in  WIDTH   raw asynchronous pin levels
//   irq       out 1       pin-change interrupt request (level)
// Register window: PIN=BASE, DDR=BASE+1, PORT=BASE+2, PCMSK=BASE+3,
// PCIFR=BASE+4 ({6'b0, pcie, pcif}).
// -----------------------------------------------------------------------------
module avr_gpio_port
  import avr_io_pkg::*;
#(
  parameter logic [7:0] BASE  = 8'h16,
  parameter int         WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       io_addr,
  input  logic             io_wr,
  input  logic             io_rd,
  input  logic [7:0]       io_wdata,
  output logic [7:0]       io_rdata,
  output logic             io_sel,
  output logic [WIDTH-1:0] port,
  output logic [WIDTH-1:0] ddr,
  input  logic [WIDTH-1:0] pin,
  output logic             irq
);

  logic [WIDTH-1:0] pcmsk;
  logic             pcie;
  logic             pcif;

  logic [WIDTH-1:0] pin_s2;
  logic [WIDTH-1:0] pin_change;
  logic             change_hit;

  logic [7:0]       addr8;
  logic [7:0]       offset;
  io_reg_e          reg_sel;
  logic [WIDTH-1:0] wdata_w;

  // The read strobe carries no side effects in this block.
  logic             unused_rd;
  assign unused_rd = io_rd;

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  gpio_sync #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (pin),
    .s2     (pin_s2),
    .change (pin_change)
  );

  assign change_hit = |(pin_change & pcmsk);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign addr8   = {2'b00, io_addr};
  assign offset  = addr8 - BASE;
  // Both bounds are needed: the subtraction wraps for addresses below BASE.
  assign io_sel  = (addr8 >= BASE) && (offset <= OFF_LAST);
  assign reg_sel = decode_reg(io_sel, offset);
  assign wdata_w = io_wdata[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      port  <= '0;
      ddr   <= '0;
      pcmsk <= '0;
      pcie  <= 1'b0;
      pcif  <= 1'b0;
    end else begin
      if (io_wr) begin
        unique case (reg_sel)
          REG_PIN:   port  <= port ^ wdata_w;
          REG_DDR:   ddr   <= wdata_w;
          REG_PORT:  port  <= wdata_w;
          REG_PCMSK: pcmsk <= wdata_w;
          REG_PCIFR: pcie  <= io_wdata[PCIE_BIT];
          default:   ;
        endcase
      end

      // A detected change takes priority over a same-cycle write-1-to-clear
      // so an event arriving during the acknowledge is never dropped.
      if (change_hit) begin
        pcif <= 1'b1;
      end else if (io_wr && (reg_sel == REG_PCIFR) && io_wdata[PCIF_BIT]) begin
        pcif <= 1'b0;
      end
    end
  end

  assign irq = pcif & pcie;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // NOTE: every output of this combinational block is given a default first,
  // so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    io_rdata = 8'h00;
    unique case (reg_sel)
      REG_PIN:   io_rdata[WIDTH-1:0] = pin_s2;
      REG_DDR:   io_rdata[WIDTH-1:0] = ddr;
      REG_PORT:  io_rdata[WIDTH-1:0] = port;
      REG_PCMSK: io_rdata[WIDTH-1:0] = pcmsk;
      REG_PCIFR: begin
        io_rdata[PCIE_BIT] = pcie;
        io_rdata[PCIF_BIT] = pcif;
      end
      default:   io_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_avr_gpio_port.sv
// -----------------------------------------------------------------------------
// tb_avr_gpio_port
// Directed bench for avr_gpio_port: a table of single-cycle register accesses
// followed by hand-written sequences for synchroniser latency, pin-change
// flagging, write-1-to-clear and its collision with a new event.
// -----------------------------------------------------------------------------
module tb_avr_gpio_port;

  localparam logic [5:0] A_PIN   = 6'h16;
  localparam logic [5:0] A_DDR   = 6'h17;
  localparam logic [5:0] A_PORT  = 6'h18;
  localparam logic [5:0] A_PCMSK = 6'h19;
  localparam logic [5:0] A_PCIFR = 6'h1A;

  logic       clk;
  logic       reset;
  logic [5:0] io_addr;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_sel;
  logic [7:0] port;
  logic [7:0] ddr;
  logic [7:0] pin;
  logic       irq;

  int checks = 0;
  int errors = 0;

  avr_gpio_port #(
    .BASE  (8'h16),
    .WIDTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_addr  (io_addr),
    .io_wr    (io_wr),
    .io_rd    (io_rd),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_sel   (io_sel),
    .port     (port),
    .ddr      (ddr),
    .pin      (pin),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_sel;
    logic [7:0] exp_port;
    logic [7:0] exp_ddr;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", name, actual, expected);
    end
  endtask

  // Write one register: strobe presented at a negedge, lands on the next
  // posedge; returns 1 time unit after that edge.
  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr  = a;
    io_wdata = d;
    io_wr    = 1'b1;
    io_rd    = 1'b0;
    @(posedge clk);
    #1;
    io_wr    = 1'b0;
  endtask

  // Combinational read; call only away from a posedge.
  task automatic read_check(input string name, input logic [5:0] a, input logic [7:0] expected);
    io_addr = a;
    io_rd   = 1'b1;
    #1;
    check(name, io_rdata, expected);
    io_rd   = 1'b0;
  endtask

  initial begin
    io_addr  = 6'h00;
    io_wr    = 1'b0;
    io_rd    = 1'b0;
    io_wdata = 8'h00;
    pin      = 8'h00;
    reset    = 1'b1;

    // ---- Reset beats a same-cycle DDR write ---------------------------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    io_addr  = A_DDR;
    io_wdata = 8'hA5;
    io_wr    = 1'b1;
    @(posedge clk);
    #1;
    io_wr = 1'b0;
    check("ddr_under_reset", ddr, 8'h00);
    check("port_under_reset", port, 8'h00);
    check("irq_under_reset", {7'b0, irq}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // ---- Table-driven register accesses -------------------------------------
    //               wr    addr     wdata  rdata  sel   port   ddr    irq
    vecs.push_back('{1'b0, A_PIN,   8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, A_DDR,   8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, A_PORT,  8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, A_PCMSK, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b0, A_PCIFR, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b1, A_PORT,  8'h3C, 8'h00, 1'b1, 8'h3C, 8'h00, 1'b0});
    vecs.push_back('{1'b1, A_PIN,   8'h0F, 8'h00, 1'b1, 8'h33, 8'h00, 1'b0});
    vecs.push_back('{1'b0, A_PORT,  8'h00, 8'h33, 1'b1, 8'h33, 8'h00, 1'b0});
    vecs.push_back('{1'b1, A_DDR,   8'hF0, 8'h00, 1'b1, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b0, A_DDR,   8'h00, 8'hF0, 1'b1, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b0, 6'h15,   8'h00, 8'h00, 1'b0, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b0, 6'h1B,   8'h00, 8'h00, 1'b0, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b1, 6'h1B,   8'hFF, 8'h00, 1'b0, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b1, 6'h02,   8'h55, 8'h00, 1'b0, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b1, A_PCMSK, 8'h5A, 8'h00, 1'b1, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b0, A_PCMSK, 8'h00, 8'h5A, 1'b1, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b1, A_PCMSK, 8'h00, 8'h00, 1'b1, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b1, A_PCIFR, 8'h02, 8'h00, 1'b1, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b0, A_PCIFR, 8'h00, 8'h02, 1'b1, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b1, A_PCIFR, 8'h00, 8'h00, 1'b1, 8'h33, 8'hF0, 1'b0});
    vecs.push_back('{1'b0, A_PCIFR, 8'h00, 8'h00, 1'b1, 8'h33, 8'hF0, 1'b0});

    foreach (vecs[i]) begin
      @(negedge clk);
      io_addr  = vecs[i].addr;
      io_wdata = vecs[i].wdata;
      io_wr    = vecs[i].wr;
      io_rd    = ~vecs[i].wr;
      #1;
      check($sformatf("v%0d_sel", i), {7'b0, io_sel}, {7'b0, vecs[i].exp_sel});
      if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
      @(posedge clk);
      #1;
      io_wr = 1'b0;
      io_rd = 1'b0;
      check($sformatf("v%0d_port", i), port, vecs[i].exp_port);
      check($sformatf("v%0d_ddr", i), ddr, vecs[i].exp_ddr);
      check($sformatf("v%0d_irq", i), {7'b0, irq}, {7'b0, vecs[i].exp_irq});
    end

    // ---- Synchroniser latency (pcmsk = 0) -----------------------------------
    @(negedge clk);
    pin = 8'h81;
    @(posedge clk);                 // first sampling edge
    @(negedge clk);
    read_check("pin_after_1_edge", A_PIN, 8'h00);
    @(posedge clk);                 // second edge
    @(negedge clk);
    read_check("pin_after_2_edges", A_PIN, 8'h81);
    repeat (3) @(negedge clk);
    read_check("pin_stable", A_PIN, 8'h81);
    check("irq_masked_change", {7'b0, irq}, 8'h00);
    read_check("pcifr_masked_change", A_PCIFR, 8'h00);

    pin = 8'h00;
    repeat (4) @(negedge clk);

    // ---- Pin-change flag: 2 sync edges + 1 flag edge -------------------------
    do_write(A_PCMSK, 8'h01);
    do_write(A_PCIFR, 8'h02);
    @(negedge clk);
    pin = 8'h01;
    @(posedge clk);                 // edge 1
    @(negedge clk);
    check("irq_edge1", {7'b0, irq}, 8'h00);
    @(posedge clk);                 // edge 2
    @(negedge clk);
    check("irq_edge2", {7'b0, irq}, 8'h00);
    read_check("pcifr_edge2", A_PCIFR, 8'h02);
    @(posedge clk);                 // edge 3
    @(negedge clk);
    check("irq_edge3", {7'b0, irq}, 8'h01);
    read_check("pcifr_edge3", A_PCIFR, 8'h03);

    // ---- W1C clears pcif, pcie stays ----------------------------------------
    do_write(A_PCIFR, 8'h03);
    check("irq_after_w1c", {7'b0, irq}, 8'h00);
    read_check("pcifr_after_w1c", A_PCIFR, 8'h02);

    // ---- Unmasked bit only changes: no flag ---------------------------------
    @(negedge clk);
    pin = 8'h03;
    repeat (5) @(negedge clk);
    check("irq_unmasked_bit", {7'b0, irq}, 8'h00);
    read_check("pcifr_unmasked_bit", A_PCIFR, 8'h02);

    // ---- Change detect coincides with W1C: set wins --------------------------
    @(negedge clk);
    pin = 8'h02;                    // pin[0] falls
    @(posedge clk);                 // edge 1: s1 updates
    @(posedge clk);                 // edge 2: s2 updates, change active
    @(negedge clk);
    io_addr  = A_PCIFR;
    io_wdata = 8'h03;
    io_wr    = 1'b1;
    @(posedge clk);                 // edge 3: set and clear collide
    #1;
    io_wr = 1'b0;
    check("irq_collision", {7'b0, irq}, 8'h01);
    read_check("pcifr_collision", A_PCIFR, 8'h03);

    // ---- pcie masks irq without touching pcif -------------------------------
    do_write(A_PCIFR, 8'h00);
    check("irq_pcie_off", {7'b0, irq}, 8'h00);
    read_check("pcifr_pcie_off", A_PCIFR, 8'h01);
    do_write(A_PCIFR, 8'h02);
    check("irq_pcie_on", {7'b0, irq}, 8'h01);
    read_check("pcifr_pcie_on", A_PCIFR, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
